// File: rtl/lut_const_div_16bit.sv
// lut_const_div_16bit: divides a 16-bit unsigned dividend by the constant A_CONST (1..255), giving quotient and remainder.
// Latency: result valid 8 cycles after the accepting edge; one op per 10 cycles with out_ready held high.
// Backpressure: accepts only in IDLE; DONE holds out_q/out_r/out_valid unchanged until out_ready.
// Optional feature macro: LUT_DIV_EXACT_EN adds out_exact (R==0 and Q<=255).
module lut_const_div_16bit #(
  parameter int A_CONST = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_c,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_q,
  output logic [7:0]  out_r
`ifdef LUT_DIV_EXACT_EN
  ,
  output logic        out_exact
`endif
);

  // A divisor outside 1..255 would overflow the 8-bit remainder or divide by zero.
  if (A_CONST < 1 || A_CONST > 255) begin : g_bad_a_const
    $error("lut_const_div_16bit: A_CONST=%0d is outside 1..255", A_CONST);
  end

  // Multiples table: one entry per nonzero radix-4 digit. The largest partial
  // remainder is 4*(A-1)+3 < 1024, so 10 bits cover both P and 3A.
  localparam logic [9:0] M1 = 10'(A_CONST);
  localparam logic [9:0] M2 = 10'(2 * A_CONST);
  localparam logic [9:0] M3 = 10'(3 * A_CONST);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] d_q, d_d;        // dividend, consumed two bits per digit from the top
  logic [13:0] wq_q, wq_d;      // first seven quotient digits; the eighth goes straight to out_q
  logic [7:0]  r_q, r_d;        // partial remainder, always < A_CONST
  logic [2:0]  cnt_q, cnt_d;    // digit index within CALC
  logic [15:0] oq_q, oq_d;
  logic [7:0]  or_q, or_d;

  logic [9:0]  p;
  logic [9:0]  sub;
  logic [1:0]  k;
  logic [7:0]  r_nxt;

`ifdef LUT_DIV_EXACT_EN
  logic        ex_q, ex_d;
`endif

  // Handshake outputs: ready only in IDLE and never while reset is asserted.
  assign in_ready  = rst_n && (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_q     = oq_q;
  assign out_r     = or_q;
`ifdef LUT_DIV_EXACT_EN
  assign out_exact = ex_q;
`endif

  // One restoring radix-4 step: pick the largest multiple not exceeding P.
  always_comb begin
    p   = {r_q, d_q[15:14]};
    k   = 2'd0;
    sub = 10'd0;
    if (p >= M3) begin
      k   = 2'd3;
      sub = M3;
    end else if (p >= M2) begin
      k   = 2'd2;
      sub = M2;
    end else if (p >= M1) begin
      k   = 2'd1;
      sub = M1;
    end
    // P - k*A < A <= 255, so the difference always fits the remainder width.
    r_nxt = 8'(p - sub);
  end

  // Next-state and datapath control; everything holds unless the state acts.
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    wq_d    = wq_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    oq_d    = oq_q;
    or_d    = or_q;
`ifdef LUT_DIV_EXACT_EN
    ex_d    = ex_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          d_d     = in_c;
          wq_d    = 14'd0;
          r_d     = 8'd0;
          cnt_d   = 3'd0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        d_d   = {d_q[13:0], 2'b00};
        wq_d  = {wq_q[11:0], k};
        r_d   = r_nxt;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          // Publish the finished result on the last digit edge.
          oq_d    = {wq_q, k};
          or_d    = r_nxt;
`ifdef LUT_DIV_EXACT_EN
          ex_d    = (r_nxt == 8'd0) && (wq_q[13:6] == 8'd0);
`endif
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      d_q     <= 16'd0;
      wq_q    <= 14'd0;
      r_q     <= 8'd0;
      cnt_q   <= 3'd0;
      oq_q    <= 16'd0;
      or_q    <= 8'd0;
`ifdef LUT_DIV_EXACT_EN
      ex_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      wq_q    <= wq_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      oq_q    <= oq_d;
      or_q    <= or_d;
`ifdef LUT_DIV_EXACT_EN
      ex_q    <= ex_d;
`endif
    end
  end

  // Invariants: partial and final remainders stay below the divisor, and a
  // stalled result does not move.
  a_rem_lt_a : assert property (@(posedge clk) disable iff (!rst_n) r_q < 8'(A_CONST));
  a_out_r_lt_a : assert property (@(posedge clk) disable iff (!rst_n)
                                  out_valid |-> (or_q < 8'(A_CONST)));
  a_stall_stable : assert property (@(posedge clk) disable iff (!rst_n)
                                    (out_valid && !out_ready) |=>
                                    (out_valid && $stable(oq_q) && $stable(or_q)));

endmodule

// File: tb/tb_lut_const_div_16bit.sv
module tb_lut_const_div_16bit;

  localparam int N = 6;
  localparam int AV [N] = '{2, 7, 1, 255, 13, 5};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] in_c = 16'd0;

  logic        in_ready  [N];
  logic        out_valid [N];
  logic [15:0] out_q     [N];
  logic [7:0]  out_r     [N];
`ifdef LUT_DIV_EXACT_EN
  logic        out_exact [N];
`endif

  int errors = 0;
  int checks = 0;
  int sb [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    lut_const_div_16bit #(.A_CONST(AV[g])) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready[g]),
      .in_c      (in_c),
      .out_valid (out_valid[g]),
      .out_ready (out_ready),
      .out_q     (out_q[g]),
      .out_r     (out_r[g])
`ifdef LUT_DIV_EXACT_EN
      ,
      .out_exact (out_exact[g])
`endif
    );
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Compare every instance's result against the arithmetic reference for dividend c.
  task automatic chk_all(input string tag, input int c);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s q A=%0d c=%0d", tag, AV[i], c), 32'(out_q[i]), 32'(c / AV[i]));
      chk($sformatf("%s r A=%0d c=%0d", tag, AV[i], c), 32'(out_r[i]), 32'(c % AV[i]));
`ifdef LUT_DIV_EXACT_EN
      chk($sformatf("%s exact A=%0d c=%0d", tag, AV[i], c), 32'(out_exact[i]),
          32'((c % AV[i] == 0) && (c / AV[i] <= 255)));
`endif
    end
  endtask

  task automatic chk_ctl(input string tag, input logic rdy, input logic vld);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s in_ready A=%0d", tag, AV[i]), 32'(in_ready[i]), 32'(rdy));
      chk($sformatf("%s out_valid A=%0d", tag, AV[i]), 32'(out_valid[i]), 32'(vld));
    end
  endtask

  // One full transaction: accept, measure latency, optional stall, handshake.
  task automatic run_op(input int c, input int hold);
    int n;
    int exp;
    n = 0;
    while (!in_ready[0] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready before accept", 32'(in_ready[0]), 32'd1);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    in_c      = 16'(c);
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back(c);
    n = 0;
    while (!out_valid[0] && n < 20) begin
      chk("in_ready while busy", 32'(in_ready[0]), 32'd0);
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("latency c=%0d", c), 32'(n), 32'd8);
    chk_ctl("done", 1'b0, 1'b1);
    exp = sb.pop_front();
    chk_all("result", exp);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk_ctl("stall", 1'b0, 1'b1);
      chk_all("stall", exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk_ctl("after handshake", 1'b1, 1'b0);
    chk_all("kept", exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a dividend already offered: nothing may be captured.
    in_valid = 1'b1;
    in_c     = 16'd14;
    #23;
    chk_ctl("reset", 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("reset q A=%0d", AV[i]), 32'(out_q[i]), 32'd0);
      chk($sformatf("reset r A=%0d", AV[i]), 32'(out_r[i]), 32'd0);
    end
    @(posedge clk); #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    chk_ctl("post reset", 1'b1, 1'b0);

    run_op(14, 0);
    run_op(16'hFFFF, 0);
    run_op(16'hABCD, 0);
    run_op(254, 0);
    run_op(1000, 5);

    // Abort an operation after its 4th digit edge; the next op must be clean.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_c      = 16'd500;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_c     = 16'd45;
    #1;
    chk_ctl("abort reset", 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_ctl("abort held", 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("abort q A=%0d", AV[i]), 32'(out_q[i]), 32'd0);
      chk($sformatf("abort r A=%0d", AV[i]), 32'(out_r[i]), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    chk_ctl("abort release", 1'b1, 1'b0);
    run_op(45, 0);

    // Round trip through the A=2 instance, back to back.
    for (int x = 0; x < 256; x++) begin
      run_op(2 * x, 0);
    end

    // Random dividends with random stalls.
    for (int t = 0; t < 20; t++) begin
      run_op(int'($urandom_range(0, 65535)), int'($urandom_range(0, 3)));
    end

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
